issue_scoreboard: RTL
=====================

Name: issue_scoreboard

Overview:
- Decode-stage hazard unit sitting directly upstream of the register file.
- Takes the four-slot instruction bundle (ALU0, ALU1, MUL, LD/ST) and tracks a busy bit per architectural register. It stalls the bundle while any operand or destination has a write still in flight.
- Clears busy bits from the same writeback tags that drive the register file write ports.
- The register file reads combinationally and writes at posedge, so an operand becomes issuable one cycle after its writeback tag is seen.

Parameters:
NREG, 32, number of architectural registers (r0 hardwired zero, never busy)
TAGW, 5, register index width
CNTW, 16, width of saturating stall-cycle counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
bundle_valid  input  1  decoded bundle present this cycle
ext_stall  input  1  downstream back-pressure; bundle must not issue
flush  input  1  branch/exception flush; clears all busy bits
a0_src0, a0_src1  input  TAGW  ALU0 source registers
a1_src0, a1_src1  input  TAGW  ALU1 source registers
m_src0, m_src1  input  TAGW  MUL source registers
ls_src0, ls_src1, ls_src2  input  TAGW  LD/ST source registers (base, offset, store data)
a0_dst, a1_dst, m_dst, ls_dst  input  TAGW  slot destinations; 0 = no write
a0_tag, a1_tag, m_tag, ls_tag  input  TAGW  writeback tags, same values driven to the register file; 0 = none
issue_stall  output  1  bundle held in decode this cycle
issue_fire  output  1  bundle issues this cycle
busy  output  NREG  registered busy vector, bit 0 always 0
stall_cnt  output  CNTW  count of cycles with issue_stall=1, saturating

Behaviour:
- Reset (rst_n=0, async): busy=0, stall_cnt=0. issue_stall and issue_fire follow from busy=0.
- Hazard terms, combinational from registered busy:
  - raw: any nonzero source of any slot has its busy bit set.
  - waw: any nonzero destination has its busy bit set.
  - dup: two slots name the same nonzero destination.
- issue_stall = bundle_valid & (raw | waw | dup).
- issue_fire = bundle_valid & ~issue_stall & ~ext_stall & ~flush.
- ext_stall does not assert issue_stall; it only suppresses issue_fire.
- Writeback tags seen in cycle N do not resolve a hazard in cycle N. Busy clears at the edge ending cycle N, so a dependent bundle fires no earlier than cycle N+1.
- Busy update at posedge, per register r≠0:
  - set if issue_fire and some slot dst==r;
  - else clear if any writeback tag==r;
  - else hold.
  - Set beats clear when both hit the same r in one cycle; the new producer owns the register.
  - Multiple tags naming the same r in one cycle clear it once; this is not an error.
- flush=1: next busy=0 regardless of tags or dests. Writebacks arriving after a flush clear already-clear bits and are harmless.
- busy[0] is forced to 0 at all times. Source or dest 0 never creates a hazard.
- stall_cnt increments by 1 each cycle issue_stall=1 and holds at all-ones. It is cleared only by reset.
- Issue latency when no hazard: 0 cycles (issue_fire in the same cycle as bundle_valid). Busy becomes visible at the next edge.

Test Plan:
- Reset mid-operation: set busy[3], busy[7], then drop rst_n asynchronously between edges → busy=0, stall_cnt=0 immediately; a following bundle reading r3 fires.
- RAW: bundle A has a0_dst=5 and fires at cycle 0; bundle B has m_src1=5 → issue_stall=1 from cycle 1. Drive a0_tag=5 in cycle 3 → issue_stall=1 in cycle 3, issue_fire=1 in cycle 4, busy[5]=0.
- Same-cycle set/clear: ls_tag=9 and an issuing bundle with a1_dst=9 in the same cycle → busy[9]=1 afterwards; a reader of r9 stalls.
- Intra-bundle WAW and r0: a0_dst=4 and m_dst=4 → stall with dup. a0_dst=0, a1_dst=0, sources all 0 → fires, busy unchanged, busy[0]=0.
- ext_stall and flush: a no-hazard bundle with ext_stall=1 → issue_stall=0, issue_fire=0, busy unchanged. With busy[2], busy[30] set, flush=1 → busy=0 next cycle.
- Counter saturation: with CNTW=4, hold a hazard for 20 cycles → stall_cnt reaches 15 and stays there.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Bundle, writeback-tag and hazard-status signals between decode and the issue scoreboard.
// The master drives the bundle and tags; the slave (scoreboard) returns stall/fire/busy/count.
interface issue_scoreboard_if #(
  parameter int NREG = 32,
  parameter int TAGW = 5,
  parameter int CNTW = 16
);
  logic            bundle_valid;
  logic            ext_stall;
  logic            flush;
  logic [TAGW-1:0] a0_src0, a0_src1;
  logic [TAGW-1:0] a1_src0, a1_src1;
  logic [TAGW-1:0] m_src0, m_src1;
  logic [TAGW-1:0] ls_src0, ls_src1, ls_src2;
  logic [TAGW-1:0] a0_dst, a1_dst, m_dst, ls_dst;
  logic [TAGW-1:0] a0_tag, a1_tag, m_tag, ls_tag;
  logic            issue_stall;
  logic            issue_fire;
  logic [NREG-1:0] busy;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output bundle_valid, ext_stall, flush,
    output a0_src0, a0_src1, a1_src0, a1_src1, m_src0, m_src1,
    output ls_src0, ls_src1, ls_src2,
    output a0_dst, a1_dst, m_dst, ls_dst,
    output a0_tag, a1_tag, m_tag, ls_tag,
    input  issue_stall, issue_fire, busy, stall_cnt
  );

  modport slave (
    input  bundle_valid, ext_stall, flush,
    input  a0_src0, a0_src1, a1_src0, a1_src1, m_src0, m_src1,
    input  ls_src0, ls_src1, ls_src2,
    input  a0_dst, a1_dst, m_dst, ls_dst,
    input  a0_tag, a1_tag, m_tag, ls_tag,
    output issue_stall, issue_fire, busy, stall_cnt
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Per-register busy scoreboard for a 4-slot bundle: 0-cycle issue when hazard-free, busy visible next edge.
// Holds the bundle (issue_stall) on RAW/WAW/duplicate-dst hazards; ext_stall and flush only suppress fire.
module issue_scoreboard #(
  parameter int NREG = 32,
  parameter int TAGW = 5,
  parameter int CNTW = 16
) (
  input logic          clk,
  input logic          rst_n,
  issue_scoreboard_if.slave sb
);

  logic [NREG-1:0] busy_q, busy_d, set_vec, clr_vec;
  logic [CNTW-1:0] cnt_q;
  logic [TAGW-1:0] srcs [9];
  logic [TAGW-1:0] dsts [4];
  logic [TAGW-1:0] tags [4];
  logic            raw, waw, dup, stall, fire;

  always_comb begin
    srcs = '{sb.a0_src0, sb.a0_src1, sb.a1_src0, sb.a1_src1, sb.m_src0, sb.m_src1,
             sb.ls_src0, sb.ls_src1, sb.ls_src2};
    dsts = '{sb.a0_dst, sb.a1_dst, sb.m_dst, sb.ls_dst};
    tags = '{sb.a0_tag, sb.a1_tag, sb.m_tag, sb.ls_tag};
  end

  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    dup = 1'b0;
    for (int i = 0; i < 9; i++)
      if (srcs[i] != '0 && busy_q[srcs[i]]) raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (dsts[i] != '0 && busy_q[dsts[i]]) waw = 1'b1;
      for (int j = i + 1; j < 4; j++)
        if (dsts[i] != '0 && dsts[i] == dsts[j]) dup = 1'b1;
    end
  end

  assign stall = sb.bundle_valid & (raw | waw | dup);
  assign fire  = sb.bundle_valid & ~stall & ~sb.ext_stall & ~sb.flush;

  // A new producer's set wins over a same-cycle writeback clear of the same register.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < 4; i++) begin
      if (fire) set_vec[dsts[i]] = 1'b1;
      clr_vec[tags[i]] = 1'b1;
    end
    busy_d = set_vec | (busy_q & ~clr_vec);
    if (sb.flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (stall && cnt_q != '1) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign sb.issue_stall = stall;
  assign sb.issue_fire  = fire;
  assign sb.busy        = busy_q;
  assign sb.stall_cnt   = cnt_q;

endmodule
